// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter with hold limit driving a registered 16:1 bit select.
module mux16_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    input  logic [15:0] data_in,
    output logic [3:0]  sel,
    output logic [15:0] grant,
    output logic        grant_valid,
    output logic        data_out
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d, sel_q, sel_d, w;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] grant_q, grant_d;
    logic        gv_q, gv_d, dout_q, dout_d, found, release_c;

    // first asserted request at or after ptr, wrapping modulo 16
    always_comb begin
        w = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found && req[ptr_q + 4'(i)]) begin
                w = ptr_q + 4'(i);
                found = 1'b1;
            end
        end
    end

    assign release_c = !req[sel_q] || !en || hold_q == 8'(HOLD_MAX);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        gv_d    = gv_q;
        dout_d  = gv_q ? data_in[sel_q] : 1'b0;
        if (state_q == IDLE) begin
            if (en && found) begin
                state_d = GRANT;
                sel_d   = w;
                grant_d = 16'b1 << w;
                gv_d    = 1'b1;
                hold_d  = 8'd1;
            end
        end else if (release_c) begin
            state_d = IDLE;
            grant_d = '0;
            gv_d    = 1'b0;
            ptr_d   = sel_q + 4'd1;
        end else begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            gv_q    <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            dout_q  <= dout_d;
        end
    end

    assign sel         = sel_q;
    assign grant       = grant_q;
    assign grant_valid = gv_q;
    assign data_out    = dout_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed and random stimulus checked each cycle against a behavioural model.
module tb_mux16_rr_arbiter;
    localparam int HM = 3;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [15:0] req = '0, data_in = '0;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        grant_valid, data_out;
    int          tests = 0, fails = 0;

    bit m_busy, m_dout;
    int m_ptr, m_sel, m_cnt;

    always #5 clk = ~clk;

    mux16_rr_arbiter #(.HOLD_MAX(HM)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .data_in(data_in),
        .sel(sel), .grant(grant), .grant_valid(grant_valid), .data_out(data_out)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_dout = 0; m_ptr = 0; m_sel = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit nb = m_busy, nd;
        int np = m_ptr, ns = m_sel, nc = m_cnt;
        nd = m_busy ? data_in[m_sel] : 1'b0;
        if (!m_busy) begin
            if (en && req != 0) begin
                for (int k = 0; k < 16; k++)
                    if (req[(m_ptr + k) % 16]) begin
                        ns = (m_ptr + k) % 16;
                        break;
                    end
                nb = 1; nc = 1;
            end
        end else if (!req[m_sel] || !en || m_cnt == HM) begin
            nb = 0; np = (m_sel + 1) % 16;
        end else begin
            nc = m_cnt + 1;
        end
        m_busy = nb; m_dout = nd; m_ptr = np; m_sel = ns; m_cnt = nc;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".grant"}, grant, m_busy ? 16'(1) << m_sel : 16'h0);
        chk({tag, ".gv"}, 16'(grant_valid), 16'(m_busy));
        chk({tag, ".sel"}, 16'(sel), 16'(m_sel));
        chk({tag, ".dout"}, 16'(data_out), 16'(m_dout));
        chk({tag, ".ptr"}, 16'(dut.ptr_q), 16'(m_ptr));
    endtask

    task automatic step(input string tag, input logic [15:0] r, input logic e, input logic [15:0] d);
        req = r; en = e; data_in = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #2 check_all("reset");
        #10 rst_n = 1'b1;

        step("single", 16'h0010, 1, 16'h0);
        chk("single.first_grant", grant, 16'h0010);
        chk("single.first_sel", 16'(sel), 16'd4);
        for (int i = 0; i < 2 * (HM + 1); i++) step("single", 16'h0010, 1, 16'h0);

        for (int i = 0; i < 9; i++) step("rr", 16'h8001, 1, 16'h0);

        step("early", 16'h0008, 1, 16'h0);
        step("early", 16'h0008, 1, 16'h0);
        step("early", 16'h0000, 1, 16'h0);
        chk("early.grant_drop", grant, 16'h0);
        chk("early.ptr", 16'(dut.ptr_q), 16'd4);
        step("early", 16'h0000, 1, 16'h0);

        for (int r = 0; r < 4; r++) begin
            step("data", 16'(1) << r, 1, 16'hA5A5);
            step("data", 16'(1) << r, 1, 16'hA5A5);
            chk("data.bit", 16'(data_out), 16'(r % 2 == 0));
            step("data", 16'h0, 1, 16'hA5A5);
            step("data", 16'h0, 1, 16'hA5A5);
        end

        step("en", 16'h0080, 1, 16'hFFFF);
        step("en", 16'h0080, 0, 16'hFFFF);
        for (int i = 0; i < 3; i++) step("en_low", 16'h0080, 0, 16'hFFFF);
        step("en_back", 16'h0080, 1, 16'hFFFF);
        chk("en_back.grant", grant, 16'h0080);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        req = 16'hFFFF;
        #2 rst_n = 1'b1;
        step("post_rst", 16'hFFFF, 1, 16'h0);
        chk("post_rst.grant0", grant, 16'h0001);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) r = m_busy ? r | (16'(1) << m_sel) : r;
            step("rand", r, $urandom_range(0, 9) != 0, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
